// File: rtl/gf2m_square_unit_if.sv
// Command / operand-RAM / result-RAM bundle for the GF(2^m) squaring engine.
// master = controller plus RAM side, slave = the squaring unit.
interface gf2m_square_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned BLK_W  = 3
);
  logic [3:0]             b_command;
  logic [BLK_W-1:0]       read_addr_inv;
  logic [9:0]             Data_len_Polynomial;
  logic [BLK_W+IDX_W-1:0] src_addr;
  logic [DATA_W-1:0]      src_data;
  logic [BLK_W+IDX_W:0]   dst_addr;
  logic [DATA_W-1:0]      dst_data;
  logic                   dst_we;
  logic                   busy;
  logic                   interupt_sqr;

  modport master (
    output b_command, read_addr_inv, Data_len_Polynomial, src_data,
    input  src_addr, dst_addr, dst_data, dst_we, busy, interupt_sqr
  );

  modport slave (
    input  b_command, read_addr_inv, Data_len_Polynomial, src_data,
    output src_addr, dst_addr, dst_data, dst_we, busy, interupt_sqr
  );
endinterface

// File: rtl/gf2m_square_unit.sv
// GF(2^m) squaring engine: reads m-bit operand word by word and writes the
// unreduced 2m-bit square (bits interleaved with zeros) to the result RAM.
module gf2m_square_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned BLK_W  = 3
) (
  input logic               clk,
  input logic               rst,
  gf2m_square_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, LO, HI, DONE} state_t;

  state_t            state;
  logic [BLK_W-1:0]  base;
  logic [9:0]        len;
  logic [IDX_W-1:0]  i;
  logic [DATA_W-1:0] w;
  logic [10:0]       rem;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] src_masked;

  function automatic logic [DATA_W-1:0] spread_half(input logic [DATA_W-1:0] x,
                                                     input logic hi);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < DATA_W / 2; k++)
      r[2*k] = hi ? x[DATA_W/2 + k] : x[k];
    return r;
  endfunction

  // rem = bits of the operand still unread at word i; it also marks the last
  // word (rem <= 32), which is the same test as i == ceil(len/32) - 1.
  always_comb begin
    rem = {1'b0, len} - 11'({i, 5'b0});
    mask = '0;
    for (int unsigned k = 0; k < DATA_W; k++)
      mask[k] = (11'(k) < rem);
    src_masked = bus.src_data & mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      base             <= '0;
      len              <= '0;
      i                <= '0;
      w                <= '0;
      bus.src_addr     <= '0;
      bus.dst_addr     <= '0;
      bus.dst_data     <= '0;
      bus.dst_we       <= 1'b0;
      bus.busy         <= 1'b0;
      bus.interupt_sqr <= 1'b0;
    end else begin
      bus.dst_we       <= 1'b0;
      bus.interupt_sqr <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.b_command == 4'h2) begin
            base     <= bus.read_addr_inv;
            len      <= bus.Data_len_Polynomial;
            i        <= '0;
            bus.busy <= 1'b1;
            if (bus.Data_len_Polynomial == 10'd0) begin
              state            <= DONE;
              bus.interupt_sqr <= 1'b1;
            end else begin
              state        <= RD;
              bus.src_addr <= {bus.read_addr_inv, {IDX_W{1'b0}}};
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          w            <= src_masked;
          bus.dst_we   <= 1'b1;
          bus.dst_addr <= {base, i, 1'b0};
          bus.dst_data <= spread_half(src_masked, 1'b0);
          state        <= LO;
        end
        LO: begin
          bus.dst_we   <= 1'b1;
          bus.dst_addr <= {base, i, 1'b1};
          bus.dst_data <= spread_half(w, 1'b1);
          state        <= HI;
        end
        HI: begin
          if (rem <= 11'd32) begin
            state            <= DONE;
            bus.interupt_sqr <= 1'b1;
          end else begin
            i            <= i + 1'b1;
            bus.src_addr <= {base, i + 1'b1};
            state        <= RD;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_square_unit.sv
// Scoreboard bench for gf2m_square_unit: stimulus pushes expected writes and
// interrupts with their cycle numbers; a negedge monitor pops and compares.
module tb_gf2m_square_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         wq[$];
  int          iq[$];
  logic [31:0] mem [0:255];

  gf2m_square_unit_if #(.DATA_W(32), .IDX_W(5), .BLK_W(3)) bus ();

  gf2m_square_unit #(.DATA_W(32), .IDX_W(5), .BLK_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.src_data <= mem[bus.src_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Spec cycle numbering: the cycle ending at edge T is cycle T.
  always @(negedge clk) begin
    wr_t e;
    int  ic;
    if (bus.dst_we === 1'b1) begin
      chk("write_expected", wq.size() != 0, 1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("wr_addr", bus.dst_addr, e.addr);
        chk("wr_data", bus.dst_data, e.data);
        chk("wr_cycle", cyc + 1, e.cyc);
      end
    end
    if (bus.interupt_sqr === 1'b1) begin
      chk("irq_expected", iq.size() != 0, 1);
      if (iq.size() != 0) begin
        ic = iq.pop_front();
        chk("irq_cycle", cyc + 1, ic);
      end
    end
  end

  task automatic push_w(input logic [2:0] base, input int o, input logic [31:0] d, input int t);
    wq.push_back('{addr: {base, 6'(o)}, data: d, cyc: t + 3 + 4 * (o / 2) + (o % 2)});
  endtask

  // Reference: whole-polynomial square, a[k] -> sq[2k], bits >= len dropped.
  task automatic push_model(input logic [2:0] base, input logic [9:0] len, input int t,
                            input int max_w, input bit with_irq);
    logic [1023:0] a;
    logic [2047:0] sq;
    int            n;
    a  = '0;
    sq = '0;
    for (int j = 0; j < 32; j++) a[32*j +: 32] = mem[{base, 5'(j)}];
    for (int k = 0; k < 1024; k++) if (k >= int'(len)) a[k] = 1'b0;
    for (int k = 0; k < 1024; k++) sq[2*k] = a[k];
    n = (int'(len) + 31) / 32;
    for (int o = 0; o < 2 * n && o < max_w; o++) push_w(base, o, sq[32*o +: 32], t);
    if (with_irq) iq.push_back(len == 10'd0 ? t + 1 : t + 4 * n + 1);
  endtask

  // Called on a negedge; returns on the negedge of cycle T+1.
  task automatic issue(input logic [2:0] base, input logic [9:0] len);
    bus.b_command           = 4'h2;
    bus.read_addr_inv       = base;
    bus.Data_len_Polynomial = len;
    @(negedge clk);
    bus.b_command = 4'h0;
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((wq.size() != 0 || iq.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", wq.size() + iq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    logic [7:0]  sa;
    bus.b_command           = 4'h0;
    bus.read_addr_inv       = '0;
    bus.Data_len_Polynomial = '0;
    for (int k = 0; k < 256; k++) mem[k] = $urandom;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_irq", bus.interupt_sqr, 0);
    chk("rst_we", bus.dst_we, 0);
    chk("rst_src_addr", bus.src_addr, 0);
    chk("rst_dst_addr", bus.dst_addr, 0);
    chk("rst_dst_data", bus.dst_data, 0);
    @(negedge clk);

    // Single full word
    mem[0] = 32'hFFFF_FFFF;
    t = cyc + 1;
    push_w(3'd0, 0, 32'h5555_5555, t);
    push_w(3'd0, 1, 32'h5555_5555, t);
    iq.push_back(t + 5);
    issue(3'd0, 10'd32);
    chk("busy_t1", bus.busy, 1);
    drain(20);

    // Masked tail
    mem[32] = 32'h0000_0001;
    mem[33] = 32'hFFFF_FFFF;
    t = cyc + 1;
    push_w(3'd1, 0, 32'h0000_0001, t);
    push_w(3'd1, 1, 32'h0000_0000, t);
    push_w(3'd1, 2, 32'h0000_5555, t);
    push_w(3'd1, 3, 32'h0000_0000, t);
    iq.push_back(t + 9);
    issue(3'd1, 10'd40);
    drain(20);

    // Zero length
    sa = bus.src_addr;
    t  = cyc + 1;
    iq.push_back(t + 1);
    issue(3'd6, 10'd0);
    drain(10);
    chk("zero_len_src_addr", bus.src_addr, sa);

    // Command while busy
    mem[64] = 32'h8000_0001;
    mem[65] = 32'h0001_8000;
    t = cyc + 1;
    push_w(3'd2, 0, 32'h0000_0001, t);
    push_w(3'd2, 1, 32'h4000_0000, t);
    push_w(3'd2, 2, 32'h4000_0000, t);
    push_w(3'd2, 3, 32'h0000_0001, t);
    iq.push_back(t + 9);
    issue(3'd2, 10'd64);
    repeat (2) @(negedge clk);
    chk("busy_t3", bus.busy, 1);
    issue(3'd5, 10'd64);
    drain(20);
    chk("busy_after_done", bus.busy, 0);

    // Reset mid-operation
    t = cyc + 1;
    push_model(3'd4, 10'd64, t, 2, 1'b0);
    issue(3'd4, 10'd64);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_we", bus.dst_we, 0);
    chk("midrst_irq", bus.interupt_sqr, 0);
    chk("midrst_src_addr", bus.src_addr, 0);
    chk("midrst_dst_addr", bus.dst_addr, 0);
    chk("midrst_dst_data", bus.dst_data, 0);
    repeat (10) @(negedge clk);
    chk("midrst_leftover", wq.size(), 0);

    // Fresh command after reset
    t = cyc + 1;
    push_model(3'd3, 10'd50, t, 64, 1'b1);
    issue(3'd3, 10'd50);
    drain(30);

    // Maximum length, top source bit must be masked off
    mem[255] = mem[255] | 32'h8000_0000;
    t = cyc + 1;
    push_model(3'd7, 10'd1023, t, 64, 1'b1);
    chk("max_writes_queued", wq.size(), 64);
    issue(3'd7, 10'd1023);
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
